// File: rtl/pipeline_front_regs.sv
// -----------------------------------------------------------------------------
// pipeline_front_regs
//   Front-end pipeline register bank of the 5-stage MIPS core: PC, IF/ID and
//   ID/EX registers, with stall / flush / branch-redirect handling, saturating
//   stall / squash / bubble counters and a sticky protocol-error flag.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   StallF, StallD, FlushE   hazard-unit controls
//   PCSrcD, PCBranchD        decode-stage branch redirect and target
//   InstrF                   instruction fetched at PCF
//   RD1D, RD2D, SignImmD     decode-stage operands
//   RsD, RtD, RdD, CtrlD     decode-stage register fields and control bundle
//   PCF, PCPlus4F            fetch PC and PC+4 (PCPlus4F is combinational)
//   InstrD, PCPlus4D, ValidD IF/ID contents
//   RD1E .. CtrlE, ValidE    ID/EX contents
//   stall_cnt, squash_cnt,
//   bubble_cnt               saturating performance counters
//   proto_err                sticky illegal-control-combination flag
// -----------------------------------------------------------------------------
module pipeline_front_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushE,
   input  logic             PCSrcD,
   input  logic [31:0]      PCBranchD,
   input  logic [31:0]      InstrF,
   input  logic [31:0]      RD1D,
   input  logic [31:0]      RD2D,
   input  logic [31:0]      SignImmD,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RdD,
   input  logic [7:0]       CtrlD,
   output logic [31:0]      PCF,
   output logic [31:0]      PCPlus4F,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic [31:0]      RD1E,
   output logic [31:0]      RD2E,
   output logic [31:0]      SignImmE,
   output logic [4:0]       RsE,
   output logic [4:0]       RtE,
   output logic [4:0]       RdE,
   output logic [7:0]       CtrlE,
   output logic             ValidE,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] squash_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic             proto_err
);

   logic [31:0]      r_pcf;
   logic [31:0]      w_pcplus4f;
   logic [31:0]      r_instr_d;
   logic [31:0]      r_pcplus4_d;
   logic             r_valid_d;
   logic [31:0]      r_rd1_e;
   logic [31:0]      r_rd2_e;
   logic [31:0]      r_simm_e;
   logic [4:0]       r_rs_e;
   logic [4:0]       r_rt_e;
   logic [4:0]       r_rd_e;
   logic [7:0]       r_ctrl_e;
   logic             r_valid_e;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_squash_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;
   logic             r_proto_err;
   logic             w_squash;
   logic             w_proto_bad;

   assign w_pcplus4f  = r_pcf + 32'd4;
   // Squash only counts when the IF/ID register is actually cleared.
   assign w_squash    = PCSrcD & ~StallD;
   // A stalled decode without an EX bubble would issue the same instruction twice.
   assign w_proto_bad = (StallF ^ StallD) | (StallD & ~FlushE);

   // PC
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pcf <= RESET_PC;
      end else if (!StallF) begin
         r_pcf <= PCSrcD ? PCBranchD : w_pcplus4f;
      end
   end

   // IF/ID: stall has priority over the branch squash
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_instr_d   <= '0;
         r_pcplus4_d <= '0;
         r_valid_d   <= 1'b0;
      end else if (StallD) begin
         r_instr_d   <= r_instr_d;
         r_pcplus4_d <= r_pcplus4_d;
         r_valid_d   <= r_valid_d;
      end else if (PCSrcD) begin
         r_instr_d   <= '0;
         r_pcplus4_d <= '0;
         r_valid_d   <= 1'b0;
      end else begin
         r_instr_d   <= InstrF;
         r_pcplus4_d <= w_pcplus4f;
         r_valid_d   <= 1'b1;
      end
   end

   // ID/EX: no stall; a flush inserts an all-zero bubble (CtrlE=0 means no writes)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd1_e   <= '0;
         r_rd2_e   <= '0;
         r_simm_e  <= '0;
         r_rs_e    <= '0;
         r_rt_e    <= '0;
         r_rd_e    <= '0;
         r_ctrl_e  <= '0;
         r_valid_e <= 1'b0;
      end else if (FlushE) begin
         r_rd1_e   <= '0;
         r_rd2_e   <= '0;
         r_simm_e  <= '0;
         r_rs_e    <= '0;
         r_rt_e    <= '0;
         r_rd_e    <= '0;
         r_ctrl_e  <= '0;
         r_valid_e <= 1'b0;
      end else begin
         r_rd1_e   <= RD1D;
         r_rd2_e   <= RD2D;
         r_simm_e  <= SignImmD;
         r_rs_e    <= RsD;
         r_rt_e    <= RtD;
         r_rd_e    <= RdD;
         r_ctrl_e  <= CtrlD;
         r_valid_e <= r_valid_d;
      end
   end

   // Saturating counters and sticky protocol flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt  <= '0;
         r_squash_cnt <= '0;
         r_bubble_cnt <= '0;
         r_proto_err  <= 1'b0;
      end else begin
         if (StallD && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_squash && (r_squash_cnt != '1)) begin
            r_squash_cnt <= r_squash_cnt + 1'b1;
         end
         if (FlushE && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         end
         if (w_proto_bad) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign PCF        = r_pcf;
   assign PCPlus4F   = w_pcplus4f;
   assign InstrD     = r_instr_d;
   assign PCPlus4D   = r_pcplus4_d;
   assign ValidD     = r_valid_d;
   assign RD1E       = r_rd1_e;
   assign RD2E       = r_rd2_e;
   assign SignImmE   = r_simm_e;
   assign RsE        = r_rs_e;
   assign RtE        = r_rt_e;
   assign RdE        = r_rd_e;
   assign CtrlE      = r_ctrl_e;
   assign ValidE     = r_valid_e;
   assign stall_cnt  = r_stall_cnt;
   assign squash_cnt = r_squash_cnt;
   assign bubble_cnt = r_bubble_cnt;
   assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_pipeline_front_regs.sv
// -----------------------------------------------------------------------------
// tb_pipeline_front_regs
//   Directed-vector bench for pipeline_front_regs with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pipeline_front_regs;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        StallF, StallD, FlushE, PCSrcD;
   logic [31:0] PCBranchD, InstrF, RD1D, RD2D, SignImmD;
   logic [4:0]  RsD, RtD, RdD;
   logic [7:0]  CtrlD;
   logic [31:0] PCF, PCPlus4F, InstrD, PCPlus4D;
   logic        ValidD, ValidE, proto_err;
   logic [31:0] RD1E, RD2E, SignImmE;
   logic [4:0]  RsE, RtE, RdE;
   logic [7:0]  CtrlE;
   logic [15:0] stall_cnt, squash_cnt, bubble_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   pipeline_front_regs #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .PCSrcD(PCSrcD),
      .PCBranchD(PCBranchD), .InstrF(InstrF),
      .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
      .RsD(RsD), .RtD(RtD), .RdD(RdD), .CtrlD(CtrlD),
      .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
      .ValidD(ValidD),
      .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
      .RsE(RsE), .RtE(RtE), .RdE(RdE), .CtrlE(CtrlE), .ValidE(ValidE),
      .stall_cnt(stall_cnt), .squash_cnt(squash_cnt), .bubble_cnt(bubble_cnt),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl(input logic sf, input logic sd, input logic fe, input logic ps,
                       input logic [31:0] tgt);
      StallF = sf; StallD = sd; FlushE = fe; PCSrcD = ps; PCBranchD = tgt;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      // reset held with random inputs
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
         InstrF = $urandom; RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
         RsD = 5'($urandom); RtD = 5'($urandom); RdD = 5'($urandom); CtrlD = 8'($urandom);
         step();
      end
      chk("rst_pcf", PCF, 32'h0);
      chk("rst_validd", {31'b0, ValidD}, 32'h0);
      chk("rst_valide", {31'b0, ValidE}, 32'h0);
      chk("rst_instrd", InstrD, 32'h0);
      chk("rst_ctrle", {24'b0, CtrlE}, 32'h0);
      chk("rst_cnts", {stall_cnt, squash_cnt | bubble_cnt}, 32'h0);
      chk("rst_proto", {31'b0, proto_err}, 32'h0);

      // release and fetch first instruction
      ctrl(0, 0, 0, 0, 32'h0);
      InstrF = 32'h2008_0005;
      RD1D = 32'h1111_1111; RD2D = 32'h2222_2222; SignImmD = 32'h0000_0005;
      RsD = 5'd1; RtD = 5'd8; RdD = 5'd3; CtrlD = 8'hA3;
      reset_n = 1'b1;
      chk("pc4f_at0", PCPlus4F, 32'h4);
      step();                                       // edge 1
      chk("e1_instrd", InstrD, 32'h2008_0005);
      chk("e1_pc4d", PCPlus4D, 32'h4);
      chk("e1_pcf", PCF, 32'h4);
      chk("e1_validd", {31'b0, ValidD}, 32'h1);
      chk("e1_valide", {31'b0, ValidE}, 32'h0);

      InstrF = 32'h8C09_0000;
      step();                                       // edge 2
      chk("e2_valide", {31'b0, ValidE}, 32'h1);
      chk("e2_rd1e", RD1E, 32'h1111_1111);
      chk("e2_rd2e", RD2E, 32'h2222_2222);
      chk("e2_regs", {17'b0, RsE, RtE, RdE}, {17'b0, 5'd1, 5'd8, 5'd3});
      chk("e2_ctrle", {24'b0, CtrlE}, 32'hA3);
      chk("e2_pcf", PCF, 32'h8);
      chk("e2_instrd", InstrD, 32'h8C09_0000);

      // load-use stall at PCF=8
      ctrl(1, 1, 1, 0, 32'h0);
      InstrF = 32'hDEAD_BEEF; CtrlD = 8'hFF;
      step();                                       // edge 3
      chk("lu_pcf", PCF, 32'h8);
      chk("lu_instrd", InstrD, 32'h8C09_0000);
      chk("lu_pc4d", PCPlus4D, 32'h8);
      chk("lu_ctrle", {24'b0, CtrlE}, 32'h0);
      chk("lu_rd1e", RD1E, 32'h0);
      chk("lu_valide", {31'b0, ValidE}, 32'h0);
      chk("lu_stall", {16'b0, stall_cnt}, 32'h1);
      chk("lu_bubble", {16'b0, bubble_cnt}, 32'h1);
      chk("lu_proto", {31'b0, proto_err}, 32'h0);

      ctrl(0, 0, 0, 0, 32'h0);
      InstrF = 32'h0000_0020; CtrlD = 8'h5A;
      step();                                       // edge 4
      chk("rs_pcf", PCF, 32'hC);
      chk("rs_instrd", InstrD, 32'h0000_0020);
      chk("rs_valide", {31'b0, ValidE}, 32'h1);
      chk("rs_ctrle", {24'b0, CtrlE}, 32'h5A);

      // branch taken at PCF=12
      ctrl(0, 0, 0, 1, 32'h40);
      step();                                       // edge 5
      chk("br_pcf", PCF, 32'h40);
      chk("br_instrd", InstrD, 32'h0);
      chk("br_pc4d", PCPlus4D, 32'h0);
      chk("br_validd", {31'b0, ValidD}, 32'h0);
      chk("br_squash", {16'b0, squash_cnt}, 32'h1);

      ctrl(0, 0, 0, 0, 32'h0);
      InstrF = 32'h1234_5678;
      step();                                       // edge 6
      chk("ab_valide", {31'b0, ValidE}, 32'h0);
      chk("ab_pcf", PCF, 32'h44);
      chk("ab_validd", {31'b0, ValidD}, 32'h1);

      // stall beats branch
      ctrl(1, 1, 1, 1, 32'h100);
      InstrF = 32'hCAFE_F00D;
      step();                                       // edge 7
      chk("sp_pcf", PCF, 32'h44);
      chk("sp_instrd", InstrD, 32'h1234_5678);
      chk("sp_validd", {31'b0, ValidD}, 32'h1);
      chk("sp_squash", {16'b0, squash_cnt}, 32'h1);
      chk("sp_stall", {16'b0, stall_cnt}, 32'h2);
      chk("sp_bubble", {16'b0, bubble_cnt}, 32'h2);

      // PC wrap
      ctrl(0, 0, 0, 1, 32'hFFFF_FFFC);
      step();                                       // edge 8
      chk("wr_pcf", PCF, 32'hFFFF_FFFC);
      chk("wr_pc4f", PCPlus4F, 32'h0);
      chk("wr_squash", {16'b0, squash_cnt}, 32'h2);
      ctrl(0, 0, 0, 0, 32'h0);
      step();                                       // edge 9
      chk("wr_pcf0", PCF, 32'h0);
      chk("wr_pc4d", PCPlus4D, 32'h0);
      chk("wr_proto", {31'b0, proto_err}, 32'h0);

      // stalled decode without flush
      ctrl(1, 1, 0, 0, 32'h0);
      step();                                       // edge 10
      chk("pe_set", {31'b0, proto_err}, 32'h1);
      ctrl(0, 0, 0, 0, 32'h0);
      step();
      step();
      chk("pe_sticky", {31'b0, proto_err}, 32'h1);

      // asynchronous reset mid-redirect discards the redirect
      ctrl(0, 0, 0, 1, 32'h80);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_pcf", PCF, 32'h0);
      chk("ar_proto", {31'b0, proto_err}, 32'h0);
      chk("ar_cnt", {stall_cnt, squash_cnt}, 32'h0);
      step();
      ctrl(0, 0, 0, 0, 32'h0);
      reset_n = 1'b1;
      step();
      chk("ar_next", PCF, 32'h4);

      // StallF without StallD
      ctrl(1, 0, 0, 0, 32'h0);
      step();
      chk("pe2_set", {31'b0, proto_err}, 32'h1);
      chk("pe2_pcf", PCF, 32'h4);

      // counter saturation
      do_reset();
      ctrl(1, 1, 1, 0, 32'h0);
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk);
      end
      #1;
      chk("sat_stall", {16'b0, stall_cnt}, 32'hFFFF);
      chk("sat_bubble", {16'b0, bubble_cnt}, 32'hFFFF);
      chk("sat_squash", {16'b0, squash_cnt}, 32'h0);
      chk("sat_pcf", PCF, 32'h0);
      chk("sat_proto", {31'b0, proto_err}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
